// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM encoding, ROM field layout and defaults for the song sequencer
package seq_pkg;
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ORDER_ADDR = 3'd1;
  localparam logic [2:0] S_ORDER_DATA = 3'd2;
  localparam logic [2:0] S_PAT_ADDR   = 3'd3;
  localparam logic [2:0] S_PAT_DATA   = 3'd4;
  localparam logic [2:0] S_OUTPUT     = 3'd5;
  localparam int ORD_ADDR_LSB = 0;
  localparam int ORD_ADDR_W   = 8;
  localparam int ORD_LEN_LSB  = 8;
  localparam int ORD_LEN_W    = 8;
  localparam int NOTE_W       = 15;
  localparam int ORDER_BASE_DEF = 0;
  typedef struct packed {
    logic [3:0] instrument;
    logic [4:0] len;
    logic [5:0] pitch;
  } note_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among requests, searching from the channel after the last grant
module rr_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  logic                    i_take,
  output logic [NUM_CHANNELS-1:0] o_grant,
  output logic [IW-1:0]           o_idx,
  output logic                    o_any
);
  logic [IW-1:0] last;
  always_comb begin
    int c;
    c = 0;
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      c = (int'(last) + 1 + i) % NUM_CHANNELS;
      if (!o_any && i_req[c]) begin
        o_any = 1'b1;
        o_idx = IW'(c);
        o_grant[c] = 1'b1;
      end
    end
  end
  // last starts at the top channel so the first search begins at ch0
  always_ff @(posedge i_clk) begin
    if (i_rst) last <= IW'(NUM_CHANNELS - 1);
    else if (i_take) last <= o_idx;
  end
endmodule

// File: rtl/multi_channel_song_sequencer.sv
// multi_channel_song_sequencer: per-channel order/pattern walker sharing one 1-cycle-latency song ROM
module multi_channel_song_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int ORDER_BASE   = ORDER_BASE_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic [ADDR_WIDTH-1:0]     i_song_len,
  input  logic [ADDR_WIDTH-1:0]     i_loop_row,
  input  logic [NUM_CHANNELS-1:0]   i_note_stb,
  output logic [NUM_CHANNELS-1:0]   o_note_valid,
  output logic [6*NUM_CHANNELS-1:0] o_note_pitch,
  output logic [5*NUM_CHANNELS-1:0] o_note_len,
  output logic [4*NUM_CHANNELS-1:0] o_note_instrument,
  output logic [NUM_CHANNELS-1:0]   o_loop,
  output logic                      o_busy,
  output logic [ADDR_WIDTH-1:0]     o_rom_addr,
  input  logic [15:0]               i_rom_data
);
  localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int AW = ADDR_WIDTH;
  logic [2:0] state;
  logic [IW-1:0] g, arb_idx;
  logic [NUM_CHANNELS-1:0] pending, need_order, req, arb_grant, take_mask, g_mask;
  logic arb_any, take, pat_end, wrap;
  logic [AW-1:0] row [NUM_CHANNELS];
  logic [AW-1:0] pat_addr [NUM_CHANNELS];
  logic [AW-1:0] pat_len [NUM_CHANNELS];
  logic [AW-1:0] count [NUM_CHANNELS];
  note_t note [NUM_CHANNELS];
  logic [AW-1:0] song_len_eff, loop_row_eff, row_next, order_addr;
  logic [ORD_LEN_W-1:0] ord_len;
  assign req = pending | i_note_stb;
  assign take = state == S_IDLE && i_enable && arb_any;
  assign take_mask = take ? arb_grant : '0;
  assign g_mask = NUM_CHANNELS'(1) << g;
  assign ord_len = i_rom_data[ORD_LEN_LSB +: ORD_LEN_W];
  always_comb begin
    song_len_eff = i_song_len == '0 ? AW'(1) : i_song_len;
    loop_row_eff = i_loop_row >= song_len_eff ? '0 : i_loop_row;
    row_next = row[g] + AW'(1);
    pat_end = count[g] >= pat_len[g];
    wrap = row_next >= song_len_eff;
    order_addr = AW'(ORDER_BASE) + row[g] * AW'(NUM_CHANNELS) + AW'(g);
  end
  assign o_busy = state != S_IDLE;
  assign o_note_valid = state == S_OUTPUT ? g_mask : '0;
  assign o_loop = (state == S_OUTPUT && pat_end && wrap) ? g_mask : '0;
  assign o_rom_addr = state == S_ORDER_ADDR ? order_addr : state == S_PAT_ADDR ? pat_addr[g] : '0;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign o_note_pitch[6*c +: 6] = note[c].pitch;
    assign o_note_len[5*c +: 5] = note[c].len;
    assign o_note_instrument[4*c +: 4] = note[c].instrument;
  end
  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS), .IW(IW)) u_arb (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req(req),
    .i_take(take),
    .o_grant(arb_grant),
    .o_idx(arb_idx),
    .o_any(arb_any)
  );
  // a same-channel strobe in the grant cycle survives only if a request was already pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      g <= '0;
      pending <= '0;
      need_order <= '1;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        row[c] <= '0;
        pat_addr[c] <= '0;
        pat_len[c] <= '0;
        count[c] <= '0;
        note[c] <= '0;
      end
    end else begin
      pending <= (pending & ~take_mask) | (i_note_stb & ~(take_mask & ~pending));
      case (state)
        S_IDLE: if (take) begin
          g <= arb_idx;
          state <= need_order[arb_idx] ? S_ORDER_ADDR : S_PAT_ADDR;
        end
        S_ORDER_ADDR: state <= S_ORDER_DATA;
        S_ORDER_DATA: begin
          pat_addr[g] <= AW'(i_rom_data[ORD_ADDR_LSB +: ORD_ADDR_W]);
          pat_len[g] <= ord_len == '0 ? AW'(1) : AW'(ord_len);
          count[g] <= AW'(1);
          need_order[g] <= 1'b0;
          state <= S_PAT_ADDR;
        end
        S_PAT_ADDR: state <= S_PAT_DATA;
        S_PAT_DATA: begin
          note[g] <= note_t'(i_rom_data[NOTE_W-1:0]);
          state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (pat_end) begin
            need_order[g] <= 1'b1;
            row[g] <= wrap ? loop_row_eff : row_next;
          end else begin
            pat_addr[g] <= pat_addr[g] + AW'(1);
            count[g] <= count[g] + AW'(1);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_channel_song_sequencer.sv
// tb_multi_channel_song_sequencer: table-driven and randomized checks of the song sequencer
module tb_multi_channel_song_sequencer;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic [7:0] song_len = 8'd1, loop_row = 8'd0;
  logic [N-1:0] stb = '0;
  logic [N-1:0] note_valid, loop_p;
  logic [6*N-1:0] pitch;
  logic [5*N-1:0] nlen;
  logic [4*N-1:0] inst;
  logic busy;
  logic [7:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] rom [256];
  int cyc = 0, tests = 0, fails = 0, last_any = -100;
  int vcnt [N], vcyc [N], row_m [N], k_m [N], scnt [N], lstb [N], vbase [N];
  logic [5:0] vp [N];
  logic [4:0] vl [N];
  logic [3:0] vi [N];
  logic vlp [N];
  bit sb_on = 1'b0;

  typedef struct { int p; int l; int i; int lat; logic lp; } note_rec_t;
  typedef struct { int sl; int lr; logic [14:0] rows; logic [4:0] lps; } row_rec_t;
  note_rec_t t1 [4];
  row_rec_t rt [3];

  multi_channel_song_sequencer #(.NUM_CHANNELS(N), .ADDR_WIDTH(8), .ORDER_BASE(0)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_enable(enable),
    .i_song_len(song_len),
    .i_loop_row(loop_row),
    .i_note_stb(stb),
    .o_note_valid(note_valid),
    .o_note_pitch(pitch),
    .o_note_len(nlen),
    .o_note_instrument(inst),
    .o_loop(loop_p),
    .o_busy(busy),
    .o_rom_addr(rom_addr),
    .i_rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  function automatic logic [15:0] nw(int p, int l, int i);
    return {1'b0, 4'(i), 5'(l), 6'(p)};
  endfunction
  function automatic logic [15:0] ow(int len, int addr);
    return {8'(len), 8'(addr)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: each channel is at (row, note index k) in the song
  task automatic model_check(input int c);
    logic [15:0] o, w;
    int plen, eff, lr;
    bit last, wr;
    o = rom[(row_m[c] * N + c) % 256];
    plen = o[15:8] == 8'd0 ? 1 : int'(o[15:8]);
    w = rom[(int'(o[7:0]) + k_m[c]) % 256];
    eff = song_len == 8'd0 ? 1 : int'(song_len);
    lr = int'(loop_row) >= eff ? 0 : int'(loop_row);
    last = k_m[c] + 1 >= plen;
    wr = last && (row_m[c] + 1 >= eff);
    check("sb_pitch", int'(vp[c]), int'(w[5:0]));
    check("sb_len", int'(vl[c]), int'(w[10:6]));
    check("sb_inst", int'(vi[c]), int'(w[14:11]));
    check("sb_loop", int'(vlp[c]), int'(wr));
    if (!last) k_m[c]++;
    else begin
      k_m[c] = 0;
      row_m[c] = wr ? lr : row_m[c] + 1;
    end
  endtask

  task automatic sample();
    logic [N-1:0] v;
    v = note_valid;
    if ((v | loop_p) != '0) check("loop_without_valid", int'(loop_p & ~v), 0);
    if (v != '0) begin
      check("valid_onehot", $countones(v), 1);
      check("valid_spacing", int'(cyc - last_any >= 4), 1);
      last_any = cyc;
    end
    for (int c = 0; c < N; c++) if (v[c]) begin
      vcnt[c]++;
      vcyc[c] = cyc;
      vp[c] = pitch[6*c +: 6];
      vl[c] = nlen[5*c +: 5];
      vi[c] = inst[4*c +: 4];
      vlp[c] = loop_p[c];
      if (sb_on) model_check(c);
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_note(input int c, output int lat);
    int v0, t0, n;
    v0 = vcnt[c];
    t0 = cyc;
    stb[c] = 1'b1;
    step();
    stb[c] = 1'b0;
    n = 0;
    while (vcnt[c] == v0 && n < 30) begin
      step();
      n++;
    end
    check("note_timeout", int'(vcnt[c] != v0), 1);
    lat = vcnt[c] != v0 ? vcyc[c] - t0 : -1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, int'(note_valid), 0);
    check({name, "_loop"}, int'(loop_p), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_addr"}, int'(rom_addr), 0);
    check({name, "_pitch"}, int'(pitch), 0);
    check({name, "_len"}, int'(nlen), 0);
    check({name, "_inst"}, int'(inst), 0);
  endtask

  initial begin
    int lat, t, e, v0, v1, v2;
    logic [N-1:0] s;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0;
    t1[0] = '{p:1, l:2, i:3, lat:5, lp:1'b0};
    t1[1] = '{p:4, l:5, i:6, lat:3, lp:1'b0};
    t1[2] = '{p:7, l:8, i:9, lat:5, lp:1'b1};
    t1[3] = '{p:1, l:2, i:3, lat:5, lp:1'b0};
    rt[0] = '{sl:3, lr:1, rows:{3'd2, 3'd1, 3'd2, 3'd1, 3'd0}, lps:5'b10100};
    rt[1] = '{sl:0, lr:0, rows:{3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, lps:5'b11111};
    rt[2] = '{sl:3, lr:5, rows:{3'd1, 3'd0, 3'd2, 3'd1, 3'd0}, lps:5'b00100};

    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;

    // single-channel walk: two-note row, one-note row, wrap to row 0
    rom[0] = ow(2, 8'h10);
    rom[4] = ow(1, 8'h20);
    rom[8'h10] = nw(1, 2, 3);
    rom[8'h11] = nw(4, 5, 6);
    rom[8'h20] = nw(7, 8, 9) | 16'h8000;
    song_len = 8'd2;
    loop_row = 8'd0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      do_note(0, lat);
      check("t1_lat", lat, t1[j].lat);
      check("t1_pitch", int'(vp[0]), t1[j].p);
      check("t1_len", int'(vl[0]), t1[j].l);
      check("t1_inst", int'(vi[0]), t1[j].i);
      check("t1_loop", int'(vlp[0]), int'(t1[j].lp));
    end

    // all four channels strobed together
    for (int c = 0; c < N; c++) begin
      rom[c] = ow(1, 8'h40 + c);
      rom[8'h40 + c] = nw(10 + c, 1, 2);
    end
    song_len = 8'd1;
    do_reset();
    for (int c = 0; c < N; c++) vbase[c] = vcnt[c];
    t = cyc;
    stb = '1;
    step();
    stb = '0;
    repeat (30) step();
    for (int c = 0; c < N; c++) begin
      check("rr_count", vcnt[c] - vbase[c], 1);
      check("rr_time", vcyc[c], t + 5 + 6 * c);
      check("rr_pitch", int'(vp[c]), 10 + c);
    end

    // coalescing and grant-cycle strobe on ch1
    rom[0] = ow(1, 8'h48);
    rom[8'h48] = nw(15, 1, 1);
    rom[1] = ow(4, 8'h50);
    for (int k = 0; k < 4; k++) rom[8'h50 + k] = nw(20 + k, 3, 4);
    do_reset();
    v1 = vcnt[1];
    t = cyc;
    stb = 4'b0001;
    step();
    stb = 4'b0010;
    repeat (3) step();
    stb = '0;
    repeat (20) step();
    check("coal_count", vcnt[1] - v1, 1);
    check("coal_time", vcyc[1], t + 11);
    check("coal_pitch", int'(vp[1]), 20);
    v1 = vcnt[1];
    t = cyc;
    stb = 4'b0001;
    step();
    stb = 4'b0010;
    step();
    stb = '0;
    repeat (4) step();
    stb = 4'b0010;
    step();
    stb = '0;
    repeat (20) step();
    check("gcyc_count", vcnt[1] - v1, 2);
    check("gcyc_time", vcyc[1], t + 13);
    check("gcyc_pitch", int'(vp[1]), 22);

    // row sequencing vs song length / loop row
    for (int r = 0; r < 8; r++) begin
      rom[4 * r] = ow(1, 8'h60 + r);
      rom[8'h60 + r] = nw(40 + r, r, 1);
    end
    for (int x = 0; x < 3; x++) begin
      song_len = 8'(rt[x].sl);
      loop_row = 8'(rt[x].lr);
      do_reset();
      for (int j = 0; j < 5; j++) begin
        do_note(0, lat);
        check("row_lat", lat, 5);
        check("row_pitch", int'(vp[0]), 40 + int'(rt[x].rows[3*j +: 3]));
        check("row_loop", int'(vlp[0]), int'(rt[x].lps[j]));
      end
    end

    // enable dropped mid-service
    rom[2] = ow(1, 8'h70);
    rom[8'h70] = nw(33, 2, 5);
    song_len = 8'd3;
    loop_row = 8'd0;
    do_reset();
    v0 = vcnt[0];
    v2 = vcnt[2];
    t = cyc;
    stb = 4'b0001;
    step();
    step();
    enable = 1'b0;
    stb = 4'b0100;
    step();
    stb = '0;
    repeat (12) step();
    check("en_inflight_count", vcnt[0] - v0, 1);
    check("en_inflight_time", vcyc[0], t + 5);
    check("en_held", vcnt[2] - v2, 0);
    check("en_idle_busy", int'(busy), 0);
    e = cyc;
    enable = 1'b1;
    repeat (10) step();
    check("en_resume_count", vcnt[2] - v2, 1);
    check("en_resume_time", vcyc[2], e + 5);
    check("en_resume_pitch", int'(vp[2]), 33);

    // reset during PAT_DATA
    do_reset();
    do_note(0, lat);
    check("rst_pre_pitch", int'(vp[0]), 40);
    v0 = vcnt[0];
    stb = 4'b0001;
    step();
    stb = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_idle_outputs("midrst");
    rst = 1'b0;
    repeat (10) step();
    check("midrst_no_valid", vcnt[0] - v0, 0);
    do_note(0, lat);
    check("midrst_refetch_lat", lat, 5);
    check("midrst_refetch_pitch", int'(vp[0]), 40);

    // randomized traffic against the reference model
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
    for (int a = 0; a < 32; a++) rom[a] = ow($urandom_range(0, 3), $urandom_range(0, 255));
    song_len = 8'($urandom_range(0, 8));
    loop_row = 8'($urandom_range(0, 9));
    do_reset();
    for (int c = 0; c < N; c++) begin
      row_m[c] = 0;
      k_m[c] = 0;
      scnt[c] = 0;
      lstb[c] = 0;
      vbase[c] = vcnt[c];
    end
    sb_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) s[c] = ($urandom % 6) == 0;
      stb = s;
      enable = ($urandom % 10) != 0;
      for (int c = 0; c < N; c++) if (s[c]) begin
        scnt[c]++;
        lstb[c] = cyc;
      end
      step();
    end
    stb = '0;
    enable = 1'b1;
    repeat (60) step();
    sb_on = 1'b0;
    check("rand_final_busy", int'(busy), 0);
    for (int c = 0; c < N; c++) begin
      check("rand_notes_le_strobes", int'(vcnt[c] - vbase[c] <= scnt[c]), 1);
      if (scnt[c] > 0) check("rand_last_strobe_served", int'(vcyc[c] >= lstb[c] + 3), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_channel_song_sequencer.md
Name: multi_channel_song_sequencer

Overview:
- N-channel successor to the single-channel pattern sequencer. Each voice channel walks its own order list and patterns in one shared 16-bit song ROM.
- Per-channel note strobes from the tick/tempo logic are latched. A round-robin arbiter then services them one at a time through a single ROM port with 1-cycle read latency.
- Sits between the tempo divider and the per-channel voice/envelope units.
- Adds over the previous generation: channel count, runtime song length and loop row, strobe queueing, and a loop indication.

Parameters:
- NUM_CHANNELS, 4, number of independent voice channels (1..8).
- ADDR_WIDTH, 8, ROM address width; also the width of row, pattern address and pattern length.
- ORDER_BASE, 0, ROM word address of order row 0, channel 0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  1  permits new grants; in-flight service always completes
- i_song_len  in  ADDR_WIDTH  number of order rows; 0 is treated as 1
- i_loop_row  in  ADDR_WIDTH  row to wrap to; a value >= effective song length is treated as 0
- i_note_stb  in  NUM_CHANNELS  per-channel request for the next note
- o_note_valid  out  NUM_CHANNELS  1-cycle pulse when that channel's note fields update
- o_note_pitch  out  6*NUM_CHANNELS  packed per channel; ch0 in the LSBs
- o_note_len  out  5*NUM_CHANNELS  packed per channel
- o_note_instrument  out  4*NUM_CHANNELS  packed per channel
- o_loop  out  NUM_CHANNELS  1-cycle pulse when a channel wraps from the last row
- o_busy  out  1  FSM not in IDLE
- o_rom_addr  out  ADDR_WIDTH  ROM address
- i_rom_data  in  16  ROM data, valid the cycle after the address

Behaviour:
- ROM formats:
  - Order entry at ORDER_BASE + row*NUM_CHANNELS + ch: [7:0] pattern start address, [15:8] pattern length (0 treated as 1).
  - Note word: [5:0] pitch, [10:6] len, [14:11] instrument, [15] ignored.
- Reset: FSM=IDLE; pending=0; all rows=0; need_order=1 for all channels; note fields=0; o_note_valid=0; o_loop=0; o_rom_addr=0.
  - Reset mid-service abandons the service; no valid pulse is produced.
- Request latching:
  - pending[ch] is set by i_note_stb[ch] and cleared on grant.
  - A strobe arriving while pending[ch] is already set is coalesced (no second note).
  - A strobe in the grant cycle for the same channel is kept as a new pending request.
- Arbitration:
  - In IDLE with i_enable=1, a channel is chosen from (pending | i_note_stb).
  - Round robin, starting from the channel after the last one granted; after reset the search starts at ch0.
- FSM states: IDLE, ORDER_ADDR, ORDER_DATA, PAT_ADDR, PAT_DATA, OUTPUT.
  - IDLE -> ORDER_ADDR if need_order[g], else -> PAT_ADDR.
  - ORDER_ADDR: o_rom_addr = order address.
  - ORDER_DATA: latch pat_addr and pat_len; count=1; clear need_order.
  - PAT_ADDR: o_rom_addr = pat_addr[g].
  - PAT_DATA: latch note fields for g.
  - OUTPUT: o_note_valid[g]=1, then -> IDLE.
  - o_rom_addr = 0 in all other states.
- Latency from a strobe in cycle T with the FSM idle: valid in T+5 with an order fetch, T+3 without.
- Pattern advance in OUTPUT:
  - If count < len: pat_addr+1, count+1.
  - Else: need_order=1 and the row advances.
  - Row advance: if row+1 >= effective song length, row = effective loop row and o_loop[g] pulses in the same cycle as valid.
- Arithmetic is modulo 2^ADDR_WIDTH.
- i_song_len and i_loop_row are sampled only at wrap time.
- Note fields for a channel hold until its next OUTPUT.

Decomposition:
- Package seq_pkg: FSM state encoding; note and order field offsets/widths; ORDER_BASE default.
- Sub-module rr_arbiter (NUM_CHANNELS): pending/request in, one-hot grant and encoded index out, last-grant pointer.

Test Plan:
- NUM_CHANNELS=1, song_len=2, loop_row=0; row0 = {addr 0x10, len 2}, row1 = {addr 0x20, len 1}; 4 strobes -> notes from 0x10, 0x11, 0x20, 0x10; o_loop with the 3rd note; valid latencies 5, 3, 5, 5.
- Strobes on ch0..ch3 in the same cycle -> grants in order 0, 1, 2, 3; exactly four valid pulses, each on the correct channel; no two within 3 cycles.
- Strobe on ch1 repeated while pending -> exactly one note; a strobe in the grant cycle -> a second note follows.
- song_len=3, loop_row=1 -> row sequence 0, 1, 2, 1, 2; song_len=0 -> row stays 0; loop_row=5 with song_len=3 -> wraps to 0.
- i_enable dropped mid-service -> current note still completes; pending requests held; service resumes when re-enabled.
- i_rst asserted during PAT_DATA -> no valid; all outputs 0; next strobe refetches order row 0.
